// File: rtl/jk_excite_ctrl.sv
// jk_excite_ctrl: computes per-bit J/K excitation that walks a modelled
// WIDTH-bit JK register toward a commanded target, either in a single jump
// or by counting up one per cycle (wrapping through all-ones).
// Optional build macro: JK_TOGGLE_EN -- changed bits use J=K=1 (toggle)
// instead of set/reset encoding. The q/done/steps/busy sequences are the
// same either way; only j/k differ.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready high
// DRIVE | applying one JK edge per cycle until q reaches the target
// DONE  | one-cycle completion pulse, q holds, then back to IDLE
module jk_excite_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [WIDTH-1:0] cmd_tgt,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [7:0]       steps
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             mode_q, mode_d;
  logic [7:0]       steps_q, steps_d;

  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] chg;
  logic [WIDTH-1:0] j_exc;
  logic [WIDTH-1:0] k_exc;
  logic [WIDTH-1:0] q_jk;

  // Excitation for one DRIVE edge, and the JK characteristic applied to it
  always_comb begin
    next_val = mode_q ? (q_q + ONE) : tgt_q;
    chg      = q_q ^ next_val;
`ifdef JK_TOGGLE_EN
    j_exc    = chg;
    k_exc    = chg;
`else
    j_exc    = chg & next_val;
    k_exc    = chg & q_q;
`endif
    // q is updated through the JK equation rather than copied from next_val,
    // so the model really exercises the excitation it publishes.
    q_jk     = (j_exc & ~q_q) | (~k_exc & q_q);
  end

  // Next-state and datapath decode
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    j_d     = '0;
    k_d     = '0;
    tgt_d   = tgt_q;
    mode_d  = mode_q;
    steps_d = steps_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          tgt_d   = cmd_tgt;
          mode_d  = cmd_mode;
          steps_d = 8'd0;
          state_d = (cmd_tgt == q_q) ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        q_d     = q_jk;
        j_d     = j_exc;
        k_d     = k_exc;
        steps_d = (steps_q == 8'hFF) ? steps_q : steps_q + 8'd1;
        if (next_val == tgt_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, async active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      tgt_q   <= '0;
      mode_q  <= 1'b0;
      steps_q <= 8'd0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      j_q     <= j_d;
      k_q     <= k_d;
      tgt_q   <= tgt_d;
      mode_q  <= mode_d;
      steps_q <= steps_d;
    end
  end

  // Handshake/status decoded from the state register only
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    q         = q_q;
    j         = j_q;
    k         = k_q;
    steps     = steps_q;
  end

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Directed self-checking bench for jk_excite_ctrl (WIDTH=4).
// Expected j/k follow the JK_TOGGLE_EN build macro when it is defined.
module tb_jk_excite_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_mode;
  logic [3:0] cmd_tgt;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic [7:0] steps;

  int n_checks;
  int n_fail;

  jk_excite_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_tgt   (cmd_tgt),
    .j         (j),
    .k         (k),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .steps     (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer a command for exactly one edge (the accept edge E0)
  task automatic issue(input logic mode, input logic [3:0] tgt);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_tgt   = tgt;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag, input logic [3:0] exp_q);
    check({tag, ".q"}, q, exp_q);
    check({tag, ".ready"}, cmd_ready, 1'b1);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".done"}, done, 1'b0);
    check({tag, ".jk"}, {j, k}, 8'h00);
  endtask

  // expected j/k for a bit-change mask and target bits
  function automatic logic [7:0] exp_jk(input logic [3:0] from_v, input logic [3:0] to_v);
    logic [3:0] c;
    c = from_v ^ to_v;
`ifdef JK_TOGGLE_EN
    return {c, c};
`else
    return {c & to_v, c & from_v};
`endif
  endfunction

  int done_cnt;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 1'b0;
    cmd_tgt   = 4'h0;

    // 1: reset during idle
    #2 rst = 1'b1;
    #1;
    check_idle("rst_hold", 4'h0);
    check("rst_hold.steps", steps, 8'd0);
    tick();
    rst = 1'b0;
    tick();
    check_idle("rst_rel", 4'h0);

    // 2: jump 0 -> A
    issue(1'b0, 4'hA);
    check("jmpA.E0.busy", busy, 1'b1);
    check("jmpA.E0.ready", cmd_ready, 1'b0);
    check("jmpA.E0.done", done, 1'b0);
    check("jmpA.E0.steps", steps, 8'd0);
    tick();
    check("jmpA.E1.q", q, 4'hA);
    check("jmpA.E1.jk", {j, k}, exp_jk(4'h0, 4'hA));
`ifndef JK_TOGGLE_EN
    check("jmpA.E1.jk_lit", {j, k}, 8'hA0);
`else
    check("jmpA.E1.jk_lit", {j, k}, 8'hAA);
`endif
    check("jmpA.E1.done", done, 1'b1);
    check("jmpA.E1.steps", steps, 8'd1);
    tick();
    check_idle("jmpA.E2", 4'hA);
    check("jmpA.E2.steps", steps, 8'd1);

    // 3: set q=E, then count E -> 1 through wrap
    issue(1'b0, 4'hE);
    tick();
    tick();
    check_idle("jmpE", 4'hE);
    issue(1'b1, 4'h1);
    tick();
    check("cnt.E1.q", q, 4'hF);
    check("cnt.E1.jk", {j, k}, exp_jk(4'hE, 4'hF));
    check("cnt.E1.done", done, 1'b0);
    tick();
    check("cnt.E2.q", q, 4'h0);
`ifndef JK_TOGGLE_EN
    check("cnt.E2.jk", {j, k}, 8'h0F);
`else
    check("cnt.E2.jk", {j, k}, 8'hFF);
`endif
    check("cnt.E2.done", done, 1'b0);
    tick();
    check("cnt.E3.q", q, 4'h1);
    check("cnt.E3.done", done, 1'b1);
    check("cnt.E3.steps", steps, 8'd3);
    tick();
    check_idle("cnt.E4", 4'h1);
    check("cnt.E4.steps", steps, 8'd3);

    // 4: q=5, count to 5 (already there)
    issue(1'b0, 4'h5);
    tick();
    tick();
    issue(1'b1, 4'h5);
    check("same.E0.done", done, 1'b1);
    check("same.E0.busy", busy, 1'b1);
    check("same.E0.steps", steps, 8'd0);
    check("same.E0.jk", {j, k}, 8'h00);
    check("same.E0.q", q, 4'h5);
    tick();
    check_idle("same.E1", 4'h5);
    check("same.E1.steps", steps, 8'd0);

    // 5: count 0 -> F, reset after 4 DRIVE edges
    issue(1'b0, 4'h0);
    tick();
    tick();
    issue(1'b1, 4'hF);
    for (int i = 0; i < 4; i++) tick();
    check("abort.pre.q", q, 4'h4);
    check("abort.pre.steps", steps, 8'd4);
    rst = 1'b1;
    #1;
    check_idle("abort.rst", 4'h0);
    check("abort.rst.steps", steps, 8'd0);
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort.no_done", done_cnt, 0);
    check_idle("abort.after", 4'h0);

    // 6: held cmd_valid during a count is ignored until IDLE
    issue(1'b1, 4'h3);
    cmd_valid = 1'b1;
    cmd_mode  = 1'b0;
    cmd_tgt   = 4'h9;
    tick();
    check("hold.E1.q", q, 4'h1);
    tick();
    check("hold.E2.q", q, 4'h2);
    tick();
    check("hold.E3.q", q, 4'h3);
    check("hold.E3.done", done, 1'b1);
    check("hold.E3.steps", steps, 8'd3);
    tick();
    check_idle("hold.E4", 4'h3);
    check("hold.E4.steps", steps, 8'd3);
    tick();
    cmd_valid = 1'b0;
    check("hold.E5.busy", busy, 1'b1);
    check("hold.E5.steps", steps, 8'd0);
    check("hold.E5.q", q, 4'h3);
    tick();
    check("hold.E6.q", q, 4'h9);
    check("hold.E6.jk", {j, k}, exp_jk(4'h3, 4'h9));
    check("hold.E6.done", done, 1'b1);
    check("hold.E6.steps", steps, 8'd1);
    tick();
    check_idle("hold.E7", 4'h9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_excite_ctrl.md
# jk_excite_ctrl

Excitation-side controller for the JK flip-flop register banks used in our behavioural designs. It accepts a target value and computes, per bit, the J/K inputs that move a WIDTH-bit JK register from its current state toward that target. A target is reached either in one jump or by counting up one per cycle. The block holds its own JK register model `q` and exposes the applied J/K vectors, so downstream JK banks or benches can be driven or checked against it.

## Interface
- `WIDTH`, default 4: register width in bits (2–16).
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `cmd_valid`, input, 1: command offered.
- `cmd_ready`, output, 1: block can accept a command. High only in IDLE.
- `cmd_mode`, input, 1: 0 = jump, 1 = count.
- `cmd_tgt`, input, WIDTH: target value.
- `j`, output, WIDTH: J excitation applied at the most recent edge.
- `k`, output, WIDTH: K excitation applied at the most recent edge.
- `q`, output, WIDTH: modelled JK register state.
- `busy`, output, 1: state is not IDLE.
- `done`, output, 1: one-cycle completion pulse.
- `steps`, output, 8: number of DRIVE edges in the current or last command. Saturates at 255.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- **IDLE**
  - A command is accepted when `cmd_valid & cmd_ready`. On accept, latch `cmd_tgt` and `cmd_mode`, and clear `steps`.
  - If `cmd_tgt == q`, go to DONE. Otherwise go to DRIVE.
- **DRIVE** (one edge per cycle)
  - next = `tgt` in jump mode; next = (`q`+1) mod 2^WIDTH in count mode.
  - Compute per-bit J/K from (`q`[i], next[i]):
    - Hold, 0→0 or 1→1: J=0, K=0.
    - Change, 0→1: J=1, K=0.
    - Change, 1→0: J=0, K=1.
    - With the macro enabled, changed bits use J=1, K=1 instead (see Configuration).
  - Update `q` by the JK characteristic equation: q+ = J·~q | ~K·q.
  - Register J/K onto `j`/`k`. Increment `steps` (saturating at 255).
  - Go to DONE when next == `tgt`; otherwise stay in DRIVE.
- **DONE**
  - `done`=1 and `j`=`k`=0 for this cycle; `q` holds. Go to IDLE.
- Count mode wraps through all-ones to zero. Distance d = (`tgt` − `q`) mod 2^WIDTH.
- `cmd_valid` during DRIVE or DONE is ignored. It is not queued and has no side effects.
- `j`/`k` are 0 in every IDLE and DONE cycle.

## Timing
- Reset (async assert, any state): `q`=0, `j`=0, `k`=0, `steps`=0, `done`=0, `busy`=0, state IDLE, so `cmd_ready`=1.
  - Reset mid-command aborts it; no `done` is produced.
- `cmd_ready`, `busy` and `done` are decoded from the state register only.
- Let E0 be the accept edge.
  - Jump with tgt≠q: E1 updates `q`=tgt and `j`/`k`. `done` is high E1–E2. Ready again after E2.
  - Count: `q` reaches tgt at edge Ed. `done` is high Ed to Ed+1.
  - tgt==q: `done` is high E0–E1; `steps`=0.
- A new command can be accepted at the first edge after `done` falls. Maximum throughput for jump mode is one command per 3 cycles.
- `steps` holds its final value until the next accept.

## Configuration
- Macro: `JK_TOGGLE_EN`.
- **Defined:** changed bits are driven with J=K=1 (toggle). Hold bits stay J=K=0.
- **Undefined:** changed bits use set/reset encoding (J=1,K=0 or J=0,K=1).
- Under either setting, the sequences of `q`, `done`, `steps` and `busy` are identical. Only `j`/`k` differ.

## Test plan
1. Reset during idle, then release. Expect `q`=0, `j`=`k`=0, `cmd_ready`=1, `busy`=0, `done`=0.
2. WIDTH=4, `q`=0, jump to 0xA.
   - One edge later: `q`=0xA, `j`=1010, `k`=0000. With `JK_TOGGLE_EN`: `j`=`k`=1010.
   - `done` pulses for one cycle; `steps`=1.
3. `q`=0xE, count to 0x1.
   - `q` goes F, 0, 1 on successive edges.
   - On the F→0 edge: `j`=0000, `k`=1111. With `JK_TOGGLE_EN`: `j`=`k`=1111.
   - `steps`=3; single `done` pulse.
4. `q`=0x5, jump or count to 0x5. Expect `done` one cycle after accept, `steps`=0, `j`=`k`=0 throughout.
5. Count 0→0xF, then assert `rst` after 4 DRIVE edges. Expect immediate `q`=0, `steps`=0, IDLE, and no `done`.
6. Hold `cmd_valid` with a new target during a count. Expect it ignored until IDLE, then accepted on the first IDLE edge, with `steps` cleared.
